cruiser_pad: RTL and testbench

CRUISER_PAD -- requirements
Module: cruiser_pad

---
 rtl/cruiser_pkg.sv | 32 +++
 rtl/cruiser_debounce.sv | 37 +++
 rtl/cruiser_pad.sv | 148 ++++++++++++++
 tb/tb_cruiser_pad.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cruiser_pkg.sv
// Shared types and default timing for the cruiser direction pad.
package cruiser_pkg;

  localparam int CNT_W_DEF         = 24;
  localparam int DEBOUNCE_DEF      = 250000;
  localparam int REPEAT_DELAY_DEF  = 15000000;
  localparam int REPEAT_PERIOD_DEF = 2500000;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  // Opposing presses cancel; the orthogonal pair passes through.
  function automatic dir_t mask_dir(input dir_t d);
    dir_t m;
    m.up    = d.up & ~d.down;
    m.down  = d.down & ~d.up;
    m.left  = d.left & ~d.right;
    m.right = d.right & ~d.left;
    return m;
  endfunction

endpackage

// File: rtl/cruiser_debounce.sv
// One button: 2-flop synchronizer followed by a stability counter.
module cruiser_debounce
  import cruiser_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int CYCLES = DEBOUNCE_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == level) begin
        cnt_q <= '0;
      end else if (cnt_q >= LAST) begin
        level <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cruiser_pad.sv
// Debounced 4-way pad with move strobe; auto-repeat when
// CRUISER_PAD_REPEAT_EN is defined, single strobe per change otherwise.
module cruiser_pad
  import cruiser_pkg::*;
#(
  parameter int CNT_W           = CNT_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic enable
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
  localparam bit PARAMS_OK =
    (longint'(DEBOUNCE_CYCLES) <= CNT_MAX) &&
    (longint'(REPEAT_DELAY) <= CNT_MAX) &&
    (longint'(REPEAT_PERIOD) <= CNT_MAX);

  logic [3:0] raw_v;
  logic [3:0] db_v;
  dir_t       masked;
  dir_t       dir_q;
  state_t     state_q;
  state_t     state_d;
  logic       enable_q;
  logic       strobe_d;
  logic       active;
  logic       changed;
  logic       term;

  assign raw_v = {btn_up, btn_down, btn_left, btn_right};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    cruiser_debounce #(
      .CNT_W  (CNT_W),
      .CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clock (clock),
      .reset (reset),
      .raw   (raw_v[i]),
      .level (db_v[i])
    );
  end

  assign masked  = mask_dir(dir_t'(db_v));
  assign active  = |masked;
  assign changed = masked != dir_q;

`ifdef CRUISER_PAD_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign term = ((state_q == DELAY) && (cnt_q >= DELAY_LAST)) ||
                ((state_q == REPEAT) && (cnt_q >= PERIOD_LAST));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign term = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      dir_q    <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= masked;
      enable_q <= strobe_d;
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef CRUISER_PAD_REPEAT_EN
    cnt_d   = cnt_q;
`endif
    if (!active) begin
      state_d = IDLE;
`ifdef CRUISER_PAD_REPEAT_EN
      cnt_d   = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = DELAY;
`ifdef CRUISER_PAD_REPEAT_EN
          cnt_d   = '0;
`endif
        end
        DELAY, REPEAT: begin
          if (changed) begin
            state_d = DELAY;
`ifdef CRUISER_PAD_REPEAT_EN
            cnt_d   = '0;
`endif
          end else if (term) begin
            state_d = REPEAT;
`ifdef CRUISER_PAD_REPEAT_EN
            cnt_d   = '0;
`endif
          end else begin
`ifdef CRUISER_PAD_REPEAT_EN
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A strobe is never issued back to back, even if events collide.
  always_comb begin
    strobe_d = 1'b0;
    if (active && !enable_q)
      strobe_d = (state_q == IDLE) || changed || term;
  end

  assign up     = dir_q.up;
  assign down   = dir_q.down;
  assign left   = dir_q.left;
  assign right  = dir_q.right;
  assign enable = enable_q;

  always_ff @(posedge clock) begin
    assert (PARAMS_OK)
      else $error("cruiser_pad: timing parameter exceeds counter range");
  end

endmodule

// File: tb/tb_cruiser_pad.sv
// Directed vector bench for cruiser_pad with short timing parameters.
module tb_cruiser_pad;

`ifdef CRUISER_PAD_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic up, down, left, right, enable;

  cruiser_pad #(
    .CNT_W           (8),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .enable    (enable)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    int         scn;
    int         e;
    logic [3:0] dir;
    logic       en;
  } vec_t;

  vec_t       vt[$];
  int         checks = 0;
  int         errors = 0;
  int         ed = 0;
  logic       prev_en = 1'b0;
  logic [4:0] tr [0:6][0:63];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int scn);
    @(posedge clock);
    #1;
    ed++;
    if (ed < 64) tr[scn][ed] = {up, down, left, right, enable};
    chk("no_double_strobe", 32'(enable & prev_en), 0);
    chk("no_idle_strobe", 32'(enable & ~(up | down | left | right)), 0);
    prev_en = enable;
  endtask

  task automatic start();
    reset = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0;
    prev_en = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1 ed = 0;
  endtask

  function automatic int count_en(input int scn, input int a, input int b);
    int n = 0;
    for (int e = a; e <= b; e++) n += int'(tr[scn][e][0]);
    return n;
  endfunction

  function automatic int count_dir(input int scn, input int a, input int b);
    int n = 0;
    for (int e = a; e <= b; e++) n += int'(|tr[scn][e][4:1]);
    return n;
  endfunction

  initial begin
    vt.push_back('{"right_e6",   1,  6, 4'b0001 & 4'b0000, 1'b0});
    vt.push_back('{"right_e7",   1,  7, 4'b0001, 1'b1});
    vt.push_back('{"right_e8",   1,  8, 4'b0001, 1'b0});
    vt.push_back('{"right_e16",  1, 16, 4'b0001, 1'b0});
    vt.push_back('{"right_e17",  1, 17, 4'b0001, REP});
    vt.push_back('{"right_e18",  1, 18, 4'b0001, 1'b0});
    vt.push_back('{"right_e20",  1, 20, 4'b0001, REP});
    vt.push_back('{"right_e23",  1, 23, 4'b0001, REP});
    vt.push_back('{"updn_e7",    3,  7, 4'b1000, 1'b1});
    vt.push_back('{"updn_e18",   3, 18, 4'b1000, 1'b0});
    vt.push_back('{"updn_e19",   3, 19, 4'b0000, 1'b0});
    vt.push_back('{"updn_e25",   3, 25, 4'b0000, 1'b0});
    vt.push_back('{"lu_e7",      4,  7, 4'b0010, 1'b1});
    vt.push_back('{"lu_e27",     4, 27, 4'b0010, 1'b0});
    vt.push_back('{"lu_e28",     4, 28, 4'b1010, 1'b1});
    vt.push_back('{"lu_e29",     4, 29, 4'b1010, 1'b0});
    vt.push_back('{"lu_e37",     4, 37, 4'b1010, 1'b0});
    vt.push_back('{"lu_e38",     4, 38, 4'b1010, REP});
    vt.push_back('{"rst_e6",     5,  6, 4'b0000, 1'b0});
    vt.push_back('{"rst_e7",     5,  7, 4'b0001, 1'b1});
    vt.push_back('{"rst_e8",     5,  8, 4'b0001, 1'b0});
    vt.push_back('{"down_e7",    6,  7, 4'b0100, 1'b1});

    #12;
    chk("reset_outputs", 32'({up, down, left, right, enable}), 0);

    start();
    btn_right = 1'b1;
    repeat (30) tick(1);

    start();
    btn_up = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(2);
      if (i % 2 == 1) btn_up = ~btn_up;
    end
    btn_up = 1'b0;
    repeat (10) tick(2);

    start();
    btn_up = 1'b1;
    repeat (12) tick(3);
    btn_down = 1'b1;
    repeat (28) tick(3);

    start();
    btn_left = 1'b1;
    repeat (21) tick(4);
    btn_up = 1'b1;
    repeat (19) tick(4);

    start();
    btn_right = 1'b1;
    repeat (21) tick(5);
    #2 reset = 1'b0;
    #1 chk("reset_mid_repeat", 32'({up, down, left, right, enable}), 0);
    prev_en = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    ed = 0;
    repeat (10) tick(5);

    start();
    btn_down = 1'b1;
    repeat (50) tick(6);

    foreach (vt[i])
      chk(vt[i].name, 32'(tr[vt[i].scn][vt[i].e]), 32'({vt[i].dir, vt[i].en}));

    chk("bounce_no_dir", count_dir(2, 1, 30), 0);
    chk("bounce_no_en", count_en(2, 1, 30), 0);
    chk("updn_no_strobe", count_en(3, 19, 40), 0);
    chk("down_strobes", count_en(6, 1, 50), REP ? 13 : 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
